// File: rtl/ntsc_timing_generator.sv
// ntsc_timing_generator: NTSC line/frame counters with registered sync, burst, blank and active decodes.
module ntsc_timing_generator #(
  parameter int LINE_CLOCKS       = 3640,
  parameter int FRAME_LINES       = 262,
  parameter int HSYNC_CLOCKS      = 269,
  parameter int EQ_CLOCKS         = 134,
  parameter int BURST_START       = 304,
  parameter int BURST_CLOCKS      = 144,
  parameter int ACTIVE_START      = 624,
  parameter int ACTIVE_END        = 3554,
  parameter int FIRST_ACTIVE_LINE = 20
) (
  input  logic        phaseClock,
  input  logic        reset,
  output logic [3:0]  subcarrierPhase,
  output logic        sync,
  output logic        burst,
  output logic        blank,
  output logic        active,
  output logic [11:0] hPos,
  output logic [8:0]  vPos,
  output logic        frameStart
);
  localparam logic [11:0] H_LAST = 12'(LINE_CLOCKS - 1);
  localparam logic [11:0] H_HALF = 12'(LINE_CLOCKS / 2);
  localparam logic [11:0] H_EQ   = 12'(EQ_CLOCKS);
  localparam logic [11:0] H_EQ2  = 12'(LINE_CLOCKS / 2 + EQ_CLOCKS);
  localparam logic [11:0] H_SER1 = 12'(LINE_CLOCKS / 2 - HSYNC_CLOCKS);
  localparam logic [11:0] H_SER2 = 12'(LINE_CLOCKS - HSYNC_CLOCKS);
  localparam logic [11:0] H_HS   = 12'(HSYNC_CLOCKS);
  localparam logic [11:0] H_BS   = 12'(BURST_START);
  localparam logic [11:0] H_BE   = 12'(BURST_START + BURST_CLOCKS);
  localparam logic [11:0] H_AS   = 12'(ACTIVE_START);
  localparam logic [11:0] H_AE   = 12'(ACTIVE_END);
  localparam logic [8:0]  V_LAST = 9'(FRAME_LINES - 1);
  localparam logic [8:0]  V_FAL  = 9'(FIRST_ACTIVE_LINE);
  typedef enum logic [2:0] {PRE_EQ, VSYNC, POST_EQ, VBLANK, PICTURE} line_t;
  line_t       state, state_n;
  logic [11:0] h_cnt;
  logic [8:0]  v_cnt, v_next;
  logic [3:0]  ph_cnt;
  logic        h_wrap, eq_line, ser_line, sync_d, burst_d, active_d;
  always_ff @(posedge phaseClock or posedge reset)
    if (reset) state <= PRE_EQ;
    else state <= state_n;
  // Line type follows the line about to start, so it only changes on the line wrap.
  always_comb begin
    h_wrap   = h_cnt == H_LAST;
    v_next   = v_cnt == V_LAST ? 9'd0 : v_cnt + 9'd1;
    state_n  = !h_wrap ? state :
               v_next < 9'd3 ? PRE_EQ :
               v_next < 9'd6 ? VSYNC :
               v_next < 9'd9 ? POST_EQ :
               v_next < V_FAL ? VBLANK : PICTURE;
    eq_line  = state == PRE_EQ || state == POST_EQ;
    ser_line = state == VSYNC;
    sync_d   = eq_line  ? (h_cnt < H_EQ || (h_cnt >= H_HALF && h_cnt < H_EQ2)) :
               ser_line ? (h_cnt < H_SER1 || (h_cnt >= H_HALF && h_cnt < H_SER2)) :
               h_cnt < H_HS;
    burst_d  = !eq_line && !ser_line && h_cnt >= H_BS && h_cnt < H_BE;
    active_d = state == PICTURE && h_cnt >= H_AS && h_cnt < H_AE;
  end
  always_ff @(posedge phaseClock or posedge reset)
    if (reset) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      ph_cnt          <= '0;
      subcarrierPhase <= '0;
      sync            <= 1'b0;
      burst           <= 1'b0;
      blank           <= 1'b1;
      active          <= 1'b0;
      hPos            <= '0;
      vPos            <= '0;
      frameStart      <= 1'b0;
    end else begin
      h_cnt           <= h_wrap ? 12'd0 : h_cnt + 12'd1;
      v_cnt           <= h_wrap ? v_next : v_cnt;
      ph_cnt          <= ph_cnt + 4'd1;
      subcarrierPhase <= ph_cnt;
      sync            <= sync_d;
      burst           <= burst_d;
      blank           <= !active_d;
      active          <= active_d;
      hPos            <= h_cnt;
      vPos            <= v_cnt;
      frameStart      <= h_cnt == 12'd0 && v_cnt == 9'd0;
    end
endmodule

// File: tb/tb_ntsc_timing_generator.sv
// tb_ntsc_timing_generator: scaled-down timing checked by a vector table, frame statistics and a position model.
module tb_ntsc_timing_generator;
  localparam int L   = 200;
  localparam int F   = 26;
  localparam int HS  = 15;
  localparam int EQ  = 7;
  localparam int BS  = 17;
  localparam int BC  = 8;
  localparam int AS  = 35;
  localparam int AE  = 190;
  localparam int FAL = 12;
  localparam int FR  = L * F;
  typedef struct {
    int n; int h; int v; int ph;
    bit s; bit b; bit a; bit f;
  } vec_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  subcarrierPhase;
  logic        sync, burst, blank, active, frameStart;
  logic [11:0] hPos;
  logic [8:0]  vPos;
  int          total = 0, bad = 0, k = 0;
  vec_t        tbl[22];
  ntsc_timing_generator #(
    .LINE_CLOCKS(L), .FRAME_LINES(F), .HSYNC_CLOCKS(HS), .EQ_CLOCKS(EQ),
    .BURST_START(BS), .BURST_CLOCKS(BC), .ACTIVE_START(AS), .ACTIVE_END(AE),
    .FIRST_ACTIVE_LINE(FAL)
  ) dut (
    .phaseClock(clk), .reset(rst), .subcarrierPhase(subcarrierPhase),
    .sync(sync), .burst(burst), .blank(blank), .active(active),
    .hPos(hPos), .vPos(vPos), .frameStart(frameStart)
  );
  always #5 clk = ~clk;
  // Clock edges seen since reset release; the outputs then describe time step k-1.
  always @(posedge clk or posedge rst)
    if (rst) k <= 0;
    else k <= k + 1;
  function automatic vec_t model(input int n);
    vec_t e;
    e.n  = n;
    e.h  = n % L;
    e.v  = (n / L) % F;
    e.ph = n % 16;
    if (e.v < 3 || (e.v >= 6 && e.v < 9)) e.s = e.h < EQ || (e.h >= L / 2 && e.h < L / 2 + EQ);
    else if (e.v < 6) e.s = e.h < L / 2 - HS || (e.h >= L / 2 && e.h < L - HS);
    else e.s = e.h < HS;
    e.b = e.v >= 9 && e.h >= BS && e.h < BS + BC;
    e.a = e.v >= FAL && e.h >= AS && e.h < AE;
    e.f = e.h == 0 && e.v == 0;
    return e;
  endfunction
  task automatic chk(input string nm, input vec_t e);
    bit ok;
    total++;
    ok = hPos == 12'(e.h) && vPos == 9'(e.v) && subcarrierPhase == 4'(e.ph) && sync == e.s &&
         burst == e.b && active == e.a && blank == !e.a && frameStart == e.f;
    if (!ok) begin
      bad++;
      if (bad <= 20)
        $display("FAIL %s n=%0d got h=%0d v=%0d ph=%0d s=%b b=%b a=%b bl=%b f=%b want h=%0d v=%0d ph=%0d s=%b b=%b a=%b bl=%b f=%b",
                 nm, e.n, hPos, vPos, subcarrierPhase, sync, burst, active, blank, frameStart,
                 e.h, e.v, e.ph, e.s, e.b, e.a, !e.a, e.f);
    end
  endtask
  task automatic cmp(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask
  task automatic wait_k(input int target);
    for (int g = 0; g < 4 * FR && k < target; g++) begin
      @(posedge clk);
      #2;
    end
    cmp("wait_budget", k, target);
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  always @(posedge clk) begin
    #1;
    if (rst) chk("reset_hold", '{0, 0, 0, 0, 0, 0, 0, 0});
    else chk("model", model(k - 1));
  end
  initial begin
    int sync1, sync4, sync12, burst12, blank12, ph12, ph13, fs_cnt, fs_last, fs_bad, n;
    vec_t e;
    tbl[0]  = '{0,    0,   0,  0,  1, 0, 0, 1};
    tbl[1]  = '{6,    6,   0,  6,  1, 0, 0, 0};
    tbl[2]  = '{7,    7,   0,  7,  0, 0, 0, 0};
    tbl[3]  = '{100,  100, 0,  4,  1, 0, 0, 0};
    tbl[4]  = '{107,  107, 0,  11, 0, 0, 0, 0};
    tbl[5]  = '{600,  0,   3,  8,  1, 0, 0, 0};
    tbl[6]  = '{684,  84,  3,  12, 1, 0, 0, 0};
    tbl[7]  = '{685,  85,  3,  13, 0, 0, 0, 0};
    tbl[8]  = '{784,  184, 3,  0,  1, 0, 0, 0};
    tbl[9]  = '{785,  185, 3,  1,  0, 0, 0, 0};
    tbl[10] = '{1817, 17,  9,  9,  0, 1, 0, 0};
    tbl[11] = '{1835, 35,  9,  11, 0, 0, 0, 0};
    tbl[12] = '{2414, 14,  12, 14, 1, 0, 0, 0};
    tbl[13] = '{2415, 15,  12, 15, 0, 0, 0, 0};
    tbl[14] = '{2417, 17,  12, 1,  0, 1, 0, 0};
    tbl[15] = '{2424, 24,  12, 8,  0, 1, 0, 0};
    tbl[16] = '{2425, 25,  12, 9,  0, 0, 0, 0};
    tbl[17] = '{2435, 35,  12, 3,  0, 0, 1, 0};
    tbl[18] = '{2589, 189, 12, 13, 0, 0, 1, 0};
    tbl[19] = '{2590, 190, 12, 14, 0, 0, 0, 0};
    tbl[20] = '{5199, 199, 25, 15, 0, 0, 0, 0};
    tbl[21] = '{5200, 0,   0,  0,  1, 0, 0, 1};
    repeat (3) @(negedge clk);
    #1 chk("reset_state", '{0, 0, 0, 0, 0, 0, 0, 0});
    @(negedge clk);
    rst = 1'b0;
    foreach (tbl[i]) begin
      wait_k(tbl[i].n + 1);
      chk("table", tbl[i]);
    end
    do_reset();
    {sync1, sync4, sync12, burst12, blank12, ph12, ph13, fs_cnt, fs_last, fs_bad} = '0;
    for (int c = 0; c < 2 * FR + 5; c++) begin
      @(posedge clk);
      #2;
      n = k - 1;
      if (n < FR && vPos == 9'd1 && sync) sync1++;
      if (n < FR && vPos == 9'd4 && sync) sync4++;
      if (n < FR && vPos == 9'd12) begin
        sync12  += int'(sync);
        burst12 += int'(burst);
        blank12 += int'(!blank);
        if (hPos == 12'(BS)) ph12 = int'(subcarrierPhase);
      end
      if (n < FR && vPos == 9'd13 && hPos == 12'(BS)) ph13 = int'(subcarrierPhase);
      if (frameStart) begin
        if (fs_cnt > 0 && n - fs_last != FR) fs_bad++;
        fs_cnt++;
        fs_last = n;
      end
    end
    cmp("eq_line_sync_cycles", sync1, 2 * EQ);
    cmp("vsync_line_sync_cycles", sync4, 2 * (L / 2 - HS));
    cmp("hsync_width", sync12, HS);
    cmp("burst_width", burst12, BC);
    cmp("blank_low_cycles", blank12, AE - AS);
    cmp("line_phase_offset", (ph13 - ph12 + 16) % 16, 8);
    cmp("frame_start_count", fs_cnt, 3);
    cmp("frame_start_period", fs_bad, 0);
    do_reset();
    wait_k(3006);
    e = model(3005);
    chk("pre_abort", e);
    cmp("pre_abort_sync", int'(sync), 1);
    #5 rst = 1'b1;
    #1 chk("async_abort", '{0, 0, 0, 0, 0, 0, 0, 0});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2 chk("restart", tbl[0]);
    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(20, 6000)) @(posedge clk);
      @(negedge clk);
      #($urandom_range(1, 4)) rst = 1'b1;
      #1 chk("rand_abort", '{0, 0, 0, 0, 0, 0, 0, 0});
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b0;
    end
    repeat (300) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ntsc_timing_generator.md
NTSC_TIMING_GENERATOR -- requirements
Module: ntsc_timing_generator

Interface
REQ-001 Parameter LINE_CLOCKS, default 3640, phaseClock periods per line (227.5 subcarrier cycles x 16).
REQ-002 Parameter FRAME_LINES, default 262, lines per non-interlaced frame.
REQ-003 Parameter HSYNC_CLOCKS, default 269, normal horizontal sync width (4.7 us).
REQ-004 Parameter EQ_CLOCKS, default 134, equalizing pulse width (2.3 us).
REQ-005 Parameters BURST_START / BURST_CLOCKS, defaults 304 / 144, burst window start and length (9 cycles).
REQ-006 Parameters ACTIVE_START / ACTIVE_END, defaults 624 / 3554, first and one-past-last active hPos.
REQ-007 Parameter FIRST_ACTIVE_LINE, default 20, first vPos carrying picture.
REQ-008 phaseClock  input  1  sole clock, 16 x subcarrier (57.27 MHz).
REQ-009 reset  input  1  asynchronous, active-high.
REQ-010 subcarrierPhase  output  4  subcarrier phase, 16 steps per cycle.
REQ-011 sync  output  1  sync-tip request.
REQ-012 burst  output  1  color-burst window.
REQ-013 blank  output  1  blanking request.
REQ-014 active  output  1  picture pixel valid.
REQ-015 hPos  output  12  position within line, 0..LINE_CLOCKS-1.
REQ-016 vPos  output  9  line number, 0..FRAME_LINES-1.
REQ-017 frameStart  output  1  one-cycle pulse at hPos=0, vPos=0.

Function
REQ-018 hCount SHALL increment every clock and wrap LINE_CLOCKS-1 -> 0; vCount SHALL increment on that wrap, wrapping FRAME_LINES-1 -> 0.
REQ-019 phaseCount (4 bits) SHALL free-run +1 per clock, independent of hCount; with the defaults this gives a line-to-line phase offset of 8 (180 deg).
REQ-020 Line-type FSM keyed on vCount: PRE_EQ (0-2), VSYNC (3-5), POST_EQ (6-8), VBLANK (9..FIRST_ACTIVE_LINE-1), PICTURE (remainder); transitions SHALL occur only at the hCount wrap.
REQ-021 PRE_EQ/POST_EQ: sync SHALL be 1 for hCount in [0,EQ_CLOCKS) and [LINE_CLOCKS/2, LINE_CLOCKS/2+EQ_CLOCKS).
REQ-022 VSYNC (serrated): sync SHALL be 1 for hCount in [0,LINE_CLOCKS/2-HSYNC_CLOCKS) and [LINE_CLOCKS/2, LINE_CLOCKS-HSYNC_CLOCKS).
REQ-023 VBLANK/PICTURE: sync SHALL be 1 for hCount in [0,HSYNC_CLOCKS).
REQ-024 burst SHALL be 1 only in VBLANK/PICTURE for hCount in [BURST_START, BURST_START+BURST_CLOCKS); never in PRE_EQ/VSYNC/POST_EQ.
REQ-025 active SHALL be 1 only in PICTURE for hCount in [ACTIVE_START, ACTIVE_END); blank SHALL equal NOT active.
REQ-026 sync and burst SHALL never both be 1; burst=1 implies blank=1.
REQ-027 All outputs SHALL be registered decodes of the counters: outputs in cycle n reflect counter values of cycle n-1, with subcarrierPhase, hPos, vPos and all flags mutually aligned (one-clock latency, consistent across outputs).
REQ-028 frameStart SHALL be 1 exactly in the output cycle where hPos=0 and vPos=0.
REQ-029 Comparisons SHALL be unsigned at 12/9 bits; LINE_CLOCKS/2 SHALL be integer division.

Reset
REQ-030 While reset=1, asynchronously: hCount, vCount, phaseCount = 0; subcarrierPhase=0, sync=0, burst=0, blank=1, active=0, hPos=0, vPos=0, frameStart=0.
REQ-031 Reset asserted mid-line or mid-frame SHALL abort immediately; no partial pulse completes.
REQ-032 First edge after reset release: counters advance to hCount=1; outputs reflect counter state hCount=0, vCount=0 (sync=1, frameStart=1, subcarrierPhase=0).

Verification
REQ-033 Release reset, run 3640 clocks -> sync high exactly 269 consecutive cycles per normal line; hPos wraps 3639 -> 0; vPos increments once.
REQ-034 Run to vPos=20 -> burst high hPos 304..447 (144 cycles), active high hPos 624..3553, blank low for exactly 2930 cycles; subcarrierPhase at hPos=304 differs by 8 between vPos=20 and 21.
REQ-035 vPos 0-2 and 6-8 -> two sync pulses of 134 cycles starting at hPos 0 and 1820; burst=0, active=0 throughout.
REQ-036 vPos 3-5 -> sync high hPos 0..1550 and 1820..3370; low 1551..1819 and 3371..3639.
REQ-037 Full frame (953680 clocks) -> frameStart pulses exactly once per frame, period 953680; every cycle checks sync&burst=0 and blank=~active.
REQ-038 Assert reset at vPos=100, hPos=1000 -> outputs take reset values without waiting for a clock; after release, sequence restarts per REQ-032.
